// File: rtl/regfile_wr_arb_if.sv
// rtl/regfile_wr_arb_if.sv - bundle of write-request, reservation and regfile-write-port signals for regfile_wr_arb
//   master: write sources, decoder reservation, regfile/scoreboard consumers
//   slave : the arbiter (regfile_wr_arb)
//   req_valid/req_addr/req_data/req_ready : per-source write requests and grants
//   resv_valid/resv_addr                  : destination reservation at issue
//   we3/wa3/wd3                           : registered regfile write port
//   grant_id, busy, err_dup               : grant index, pending-write scoreboard, sticky duplicate flag
interface regfile_wr_arb_if #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 resv_valid;
    logic [AW-1:0]        resv_addr;
    logic                 we3;
    logic [AW-1:0]        wa3;
    logic [DW-1:0]        wd3;
    logic [1:0]           grant_id;
    logic [(1<<AW)-1:0]   busy;
    logic                 err_dup;

    modport master (
        output req_valid, req_addr, req_data, resv_valid, resv_addr,
        input  req_ready, we3, wa3, wd3, grant_id, busy, err_dup
    );

    modport slave (
        input  req_valid, req_addr, req_data, resv_valid, resv_addr,
        output req_ready, we3, wa3, wd3, grant_id, busy, err_dup
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - round-robin arbiter for the shared regfile write port with pending-write scoreboard
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : regfile_wr_arb_if.slave (requests, grants, reservation, we3/wa3/wd3, grant_id, busy, err_dup)
//   Build option WRARB_FIXED_PRIO_EN: fixed priority source 0 > 1 > 2, no round-robin pointer.
module regfile_wr_arb #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int NREQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wr_arb_if.slave    bus
);
    localparam int NREG = 1 << AW;

    logic            we3_q, we3_d;
    logic [AW-1:0]   wa3_q, wa3_d;
    logic [DW-1:0]   wd3_q, wd3_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            err_dup_q, err_dup_d;

    logic [NREQ-1:0] ready_c;
    logic [1:0]      gid_c;
    logic            accept_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_data_c;
    int              start_c;

`ifdef WRARB_FIXED_PRIO_EN
    assign start_c = 0;
`else
    logic [1:0] ptr_q, ptr_d;
    assign start_c = int'(ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (accept_c) begin
            ptr_d = (int'(gid_c) == NREQ - 1) ? 2'd0 : gid_c + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Search from start_c, wrapping once; the first valid source wins.
    always_comb begin : arb_search
        int idx;
        ready_c  = '0;
        gid_c    = 2'd0;
        accept_c = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = start_c + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!accept_c && bus.req_valid[idx]) begin
                accept_c     = 1'b1;
                ready_c[idx] = 1'b1;
                gid_c        = 2'(idx);
            end
        end
    end

    assign sel_addr_c = bus.req_addr[int'(gid_c)*AW +: AW];
    assign sel_data_c = bus.req_data[int'(gid_c)*DW +: DW];

    // Writes to register 0 are accepted (and advance the pointer) but never reach the port.
    always_comb begin
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (accept_c && (sel_addr_c != '0)) begin
            we3_d = 1'b1;
            wa3_d = sel_addr_c;
            wd3_d = sel_data_c;
        end
    end

    // Clear follows the actual regfile write (registered port); a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (we3_q && (wa3_q == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (bus.resv_valid && (bus.resv_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;

        err_dup_d = err_dup_q;
        if (bus.resv_valid && (bus.resv_addr != '0) && busy_q[bus.resv_addr] &&
            !(we3_q && (wa3_q == bus.resv_addr))) begin
            err_dup_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q     <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            busy_q    <= '0;
            err_dup_q <= 1'b0;
        end else begin
            we3_q     <= we3_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            busy_q    <= busy_d;
            err_dup_q <= err_dup_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.grant_id  = gid_c;
    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;
    assign bus.busy      = busy_q;
    assign bus.err_dup   = err_dup_q;
endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb/tb_regfile_wr_arb.sv - self-checking bench for regfile_wr_arb (vector table, corner sequences, random vs reference model)
module tb_regfile_wr_arb;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    regfile_wr_arb_if #(.DW(8), .AW(4), .NREQ(3)) intf ();

    regfile_wr_arb #(.DW(8), .AW(4), .NREQ(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [11:0] a;
        logic [23:0] d;
        logic        rv;
        logic [3:0]  ra;
        logic [2:0]  e_rdy;
        logic [1:0]  e_gid;
        logic        e_we;
        logic [3:0]  e_wa;
        logic [7:0]  e_wd;
        logic [15:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl[15];

    // Reference model state
    int       m_ptr;
    bit       m_we;
    bit [3:0] m_wa;
    bit [7:0] m_wd;
    bit       m_busy[16];
    bit       m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [11:0] a, input logic [23:0] d,
                         input logic rv, input logic [3:0] ra);
        intf.req_valid  = v;
        intf.req_addr   = a;
        intf.req_data   = d;
        intf.resv_valid = rv;
        intf.resv_addr  = ra;
    endtask

    function automatic int model_pick(input logic [2:0] v);
        int p;
`ifdef WRARB_FIXED_PRIO_EN
        p = 0;
`else
        p = m_ptr;
`endif
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_busy_vec();
        logic [15:0] b;
        for (int r = 0; r < 16; r++) b[r] = m_busy[r];
        return b;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_err = 0;
        for (int r = 0; r < 16; r++) m_busy[r] = 0;
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_edge(input int g, input logic [11:0] a, input logic [23:0] d,
                              input logic rv, input logic [3:0] ra);
        int ga;
        if (rv && ra != 0 && m_busy[ra] && !(m_we && m_wa == ra)) m_err = 1;
        if (m_we) m_busy[m_wa] = 0;
        if (rv && ra != 0) m_busy[ra] = 1;
        if (g >= 0) begin
            ga = int'(a >> (4 * g)) & 15;
            m_we = (ga != 0);
            if (ga != 0) begin
                m_wa = 4'(ga);
                m_wd = 8'((d >> (8 * g)) & 24'hFF);
            end
            m_ptr = (g + 1) % 3;
        end else begin
            m_we = 0;
        end
    endtask

    initial begin
        int g;
        bit       src_v[3];
        bit [3:0] src_a[3];
        bit [7:0] src_d[3];
        logic [11:0] ra_all;
        logic [23:0] rd_all;
        logic        rrv;
        logic [3:0]  rra;
        logic [2:0]  rv_all;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        drive(3'b000, 12'h000, 24'h0, 1'b0, 4'h0);

        tbl[0]  = '{3'b111, 12'h321, 24'h332211, 1'b0, 4'h0, 3'b001, 2'd0, 1'b1, 4'h1, 8'h11, 16'h0000, 1'b0};
        tbl[1]  = '{3'b111, 12'h321, 24'h332211, 1'b0, 4'h0, 3'b010, 2'd1, 1'b1, 4'h2, 8'h22, 16'h0000, 1'b0};
        tbl[2]  = '{3'b111, 12'h321, 24'h332211, 1'b0, 4'h0, 3'b100, 2'd2, 1'b1, 4'h3, 8'h33, 16'h0000, 1'b0};
        tbl[3]  = '{3'b111, 12'h321, 24'h332211, 1'b0, 4'h0, 3'b001, 2'd0, 1'b1, 4'h1, 8'h11, 16'h0000, 1'b0};
        tbl[4]  = '{3'b010, 12'h000, 24'h00FF00, 1'b0, 4'h0, 3'b010, 2'd1, 1'b0, 4'h0, 8'h00, 16'h0000, 1'b0};
        tbl[5]  = '{3'b111, 12'h321, 24'h332211, 1'b0, 4'h0, 3'b100, 2'd2, 1'b1, 4'h3, 8'h33, 16'h0000, 1'b0};
        tbl[6]  = '{3'b000, 12'h000, 24'h000000, 1'b0, 4'h0, 3'b000, 2'd0, 1'b0, 4'h0, 8'h00, 16'h0000, 1'b0};
        tbl[7]  = '{3'b000, 12'h000, 24'h000000, 1'b1, 4'h5, 3'b000, 2'd0, 1'b0, 4'h0, 8'h00, 16'h0020, 1'b0};
        tbl[8]  = '{3'b001, 12'h005, 24'h000055, 1'b0, 4'h0, 3'b001, 2'd0, 1'b1, 4'h5, 8'h55, 16'h0020, 1'b0};
        tbl[9]  = '{3'b000, 12'h000, 24'h000000, 1'b0, 4'h0, 3'b000, 2'd0, 1'b0, 4'h0, 8'h00, 16'h0000, 1'b0};
        tbl[10] = '{3'b000, 12'h000, 24'h000000, 1'b1, 4'h7, 3'b000, 2'd0, 1'b0, 4'h0, 8'h00, 16'h0080, 1'b0};
        tbl[11] = '{3'b001, 12'h007, 24'h000077, 1'b0, 4'h0, 3'b001, 2'd0, 1'b1, 4'h7, 8'h77, 16'h0080, 1'b0};
        tbl[12] = '{3'b000, 12'h000, 24'h000000, 1'b1, 4'h7, 3'b000, 2'd0, 1'b0, 4'h0, 8'h00, 16'h0080, 1'b0};
        tbl[13] = '{3'b000, 12'h000, 24'h000000, 1'b1, 4'h7, 3'b000, 2'd0, 1'b0, 4'h0, 8'h00, 16'h0080, 1'b1};
        tbl[14] = '{3'b000, 12'h000, 24'h000000, 1'b0, 4'h0, 3'b000, 2'd0, 1'b0, 4'h0, 8'h00, 16'h0080, 1'b1};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_we3", {31'd0, intf.we3}, 32'd0);
        check("rst_busy", {16'd0, intf.busy}, 32'd0);
        check("rst_err", {31'd0, intf.err_dup}, 32'd0);
        check("rst_ready", {29'd0, intf.req_ready}, 32'd0);

`ifndef WRARB_FIXED_PRIO_EN
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].rv, tbl[i].ra);
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), {29'd0, intf.req_ready}, {29'd0, tbl[i].e_rdy});
            if (tbl[i].e_rdy != 3'b000)
                check($sformatf("tbl%0d_gid", i), {30'd0, intf.grant_id}, {30'd0, tbl[i].e_gid});
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_we3", i), {31'd0, intf.we3}, {31'd0, tbl[i].e_we});
            if (tbl[i].e_we) begin
                check($sformatf("tbl%0d_wa3", i), {28'd0, intf.wa3}, {28'd0, tbl[i].e_wa});
                check($sformatf("tbl%0d_wd3", i), {24'd0, intf.wd3}, {24'd0, tbl[i].e_wd});
            end
            check($sformatf("tbl%0d_busy", i), {16'd0, intf.busy}, {16'd0, tbl[i].e_busy});
            check($sformatf("tbl%0d_err", i), {31'd0, intf.err_dup}, {31'd0, tbl[i].e_err});
        end
`endif

        // Reset in the same cycle as an accept of addr 4 / 0xA5: the write is lost.
        drive(3'b001, 12'h004, 24'h0000A5, 1'b1, 4'h9);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(3'b000, 12'h000, 24'h0, 1'b0, 4'h0);
        check("midrst_we3", {31'd0, intf.we3}, 32'd0);
        check("midrst_busy", {16'd0, intf.busy}, 32'd0);
        check("midrst_err", {31'd0, intf.err_dup}, 32'd0);

        // All sources held valid for 6 cycles: rotation (or fixed source 0), no bubbles.
        drive(3'b111, 12'h321, 24'h332211, 1'b0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            int eg;
`ifdef WRARB_FIXED_PRIO_EN
            eg = 0;
`else
            eg = k % 3;
`endif
            @(negedge clk);
            check($sformatf("fair%0d_ready", k), {29'd0, intf.req_ready}, 32'd1 << eg);
            check($sformatf("fair%0d_gid", k), {30'd0, intf.grant_id}, eg);
            @(posedge clk);
            #1;
            check($sformatf("fair%0d_we3", k), {31'd0, intf.we3}, 32'd1);
            check($sformatf("fair%0d_wa3", k), {28'd0, intf.wa3}, eg + 1);
            check($sformatf("fair%0d_wd3", k), {24'd0, intf.wd3}, 32'h11 * (eg + 1));
        end

        // Randomized traffic against the reference model.
        drive(3'b000, 12'h000, 24'h0, 1'b0, 4'h0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int s = 0; s < 3; s++) src_v[s] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (!src_v[s] && ($urandom_range(0, 1) == 1)) begin
                    src_v[s] = 1;
                    src_a[s] = 4'($urandom_range(0, 15));
                    src_d[s] = 8'($urandom);
                end
                rv_all[s]          = src_v[s];
                ra_all[4*s +: 4]   = src_a[s];
                rd_all[8*s +: 8]   = src_d[s];
            end
            rrv = ($urandom_range(0, 3) == 0);
            rra = 4'($urandom_range(0, 15));
            drive(rv_all, ra_all, rd_all, rrv, rra);
            g = model_pick(rv_all);
            @(negedge clk);
            check("rnd_ready", {29'd0, intf.req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
            if (g >= 0) check("rnd_gid", {30'd0, intf.grant_id}, g);
            @(posedge clk);
            model_edge(g, ra_all, rd_all, rrv, rra);
            #1;
            check("rnd_we3", {31'd0, intf.we3}, {31'd0, m_we});
            if (m_we) begin
                check("rnd_wa3", {28'd0, intf.wa3}, {28'd0, m_wa});
                check("rnd_wd3", {24'd0, intf.wd3}, {24'd0, m_wd});
            end
            check("rnd_busy", {16'd0, intf.busy}, {16'd0, model_busy_vec()});
            check("rnd_err", {31'd0, intf.err_dup}, {31'd0, m_err});
            if (g >= 0) src_v[g] = 0;
            // Occasionally clear the sticky error so later duplicates are still observed.
            if (m_err && ($urandom_range(0, 63) == 0)) begin
                drive(3'b000, 12'h000, 24'h0, 1'b0, 4'h0);
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                model_reset();
                for (int s = 0; s < 3; s++) src_v[s] = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Arbiter for the single write port (we3/wa3/wd3) of the 16x8 register bank, which is shared by three write sources: ALU result, memory/load data and I/O input.
- Grants one write per cycle, round-robin between the sources.
- Registers the winning write onto the port.
- Keeps a per-register pending-write scoreboard, so the decode/control logic can stall on read-after-write hazards.

Parameters:
- DW, 8, data width of a register (matches the regfile).
- AW, 4, register address width (16 registers).
- NREQ, 3, number of write requesters. The design is verified only at 3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  write request per source.
- req_addr  in  NREQ*AW  destination register; source i uses bits [AW*i+AW-1 : AW*i].
- req_data  in  NREQ*DW  write data; source i uses bits [DW*i+DW-1 : DW*i].
- req_ready  out  NREQ  grant; a write is accepted when req_valid[i] and req_ready[i] are both high.
- resv_valid  in  1  decoder reserves a destination register at issue.
- resv_addr  in  AW  register being reserved.
- we3  out  1  regfile write enable (registered).
- wa3  out  AW  regfile write address (registered).
- wd3  out  DW  regfile write data (registered).
- grant_id  out  2  index of the source currently granted; valid only while req_ready is non-zero.
- busy  out  16  pending-write scoreboard; bit r set means register r has a write outstanding.
- err_dup  out  1  sticky error flag: a register was reserved while already busy.

Behaviour:
- Reset: synchronous, sampled at the rising edge of clk. It clears we3, wa3, wd3, busy, err_dup and the round-robin pointer ptr (ptr = 0). Reset mid-transfer discards any in-flight write: we3 is 0 in the cycle after reset.
- Arbitration is combinational within the cycle:
  - Search order is ptr, ptr+1, ptr+2 (mod 3).
  - The first source with req_valid set gets req_ready, and grant_id is set to its index.
  - At most one bit of req_ready is high. req_ready = 0 when no source is valid.
- Pointer update: on an accept by source i, ptr <= (i+1) mod 3. With no accept, ptr holds.
- Latency: a write accepted at edge N is driven on we3/wa3/wd3 during cycle N+1, and the regfile writes it at edge N+1.
- With no accept at edge N, we3 = 0 in cycle N+1; wa3 and wd3 hold their previous values.
- Throughput: one accept per cycle, with no bubbles.
- Fairness: with all three sources continuously valid, each source is granted exactly once every 3 cycles.
- Register 0:
  - A request to address 0 is still accepted and still advances ptr.
  - we3 stays 0 in the following cycle; the write is dropped silently.
- Protocol: a source holds req_valid, req_addr and req_data stable until accepted. The arbiter does not check this.
- Scoreboard:
  - Set: resv_valid with resv_addr = r, r != 0, sets busy[r] at the next edge.
  - Clear: busy[r] clears at the edge where we3 = 1 and wa3 = r, i.e. when the regfile actually writes r.
  - Simultaneous set and clear of the same r: set wins, and busy[r] stays 1.
  - Reserving 0 is ignored; busy[0] is always 0.
  - A write to a register that is not busy is legal and changes no busy bit.
- err_dup: set when resv_valid arrives for an r != 0 whose busy[r] is already 1 and is not being cleared in that same cycle. Once set, it holds until reset.

Optional Feature:
- Macro: WRARB_FIXED_PRIO_EN.
- Defined: fixed priority, source 0 > source 1 > source 2. ptr is removed, and the search always starts at source 0. Starvation of the lower-priority sources is allowed.
- Undefined: round-robin as described in Behaviour.
- Latency, the scoreboard and register-0 handling are identical in both builds.

Test Plan:
- Reset priority: after reset, req_valid = 3'b111 with addresses 1/2/3 and data 0x11/0x22/0x33, held valid. Expected: grants in order 0,1,2,0 on consecutive cycles; we3 = 1 with wa3/wd3 = 1/0x11, 2/0x22, 3/0x33 one cycle after each grant.
- Register 0: source 1 alone requests addr 0, data 0xFF. Expected: req_ready[1] = 1; we3 = 0 in the next cycle; ptr advances, so the next simultaneous 0/1/2 request grants source 2 first.
- Scoreboard round trip: reserve register 5, then source 0 writes addr 5. Expected: busy[5] = 1 from the edge after the reservation until the edge where we3 = 1 and wa3 = 5, then busy = 16'h0000.
- Simultaneous set and clear: a write to register 7 is on the port (we3 = 1, wa3 = 7) while resv_valid arrives for 7 in the same cycle. Expected: busy[7] stays 1 and err_dup stays 0. A second reservation of 7 with no write pending sets err_dup = 1, which stays 1 until reset.
- Reset mid-operation: assert reset in the same cycle as an accept of addr 4, data 0xA5. Expected: the next cycle has we3 = 0, busy = 0, err_dup = 0; the following grant goes to source 0.
- Fixed-priority build (WRARB_FIXED_PRIO_EN defined): all sources continuously valid for 6 cycles. Expected: source 0 is granted every cycle; req_ready[1] and req_ready[2] are never 1.
